led_heartbeat_driver: RTL
=========================

# led_heartbeat_driver

Consumer side of the rotating one-hot LED select. Takes the 8-bit one-hot `led_select` from the LED state machine and decodes it to a LED index. Each time the index changes, it runs a PWM breathing envelope (rise, hold, fall) on the newly selected LED. It sits between the selector and the board LED pins and produces the visible "heartbeat".

## Interface
- `PWM_BITS`, default 8: width of the PWM counter and of the duty value.
- `STEP_DIV`, default 256: clocks per envelope step; legal range ≥1.
- `HOLD_STEPS`, default 32: number of steps spent in HOLD at full duty; legal range ≥1.
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `led_select`  in  8: one-hot LED select from the selector.
- `led`  out  8: LED drive, active-high, registered.
- `sel_err`  out  1: registered; high while the sampled `led_select` is not exactly one-hot.

## Operation
- Input stage: `led_select` is registered every clock into `sel_q`.
- Decode:
  - Exactly one bit set: `idx` = that bit position, `valid` = 1.
  - Zero bits or ≥2 bits set: `sel_err` = 1, and `idx` and the envelope are left unchanged.
- Change detection: a restart fires when `valid` is set and either `idx` ≠ stored `cur_idx` or `have_idx` = 0. On restart:
  - `cur_idx` ← `idx`
  - `have_idx` ← 1
  - state ← RISE
  - duty ← 0
  - step counter ← 0
- Envelope FSM (states IDLE, RISE, HOLD, FALL). A "step" is the cycle in which the step counter equals `STEP_DIV`-1; the counter then wraps to 0.
  - IDLE: duty = 0; remains in IDLE until a restart.
  - RISE: duty += 1 each step. When duty reaches 2^`PWM_BITS`-1, go to HOLD with the hold counter = 0.
  - HOLD: hold counter += 1 each step. After `HOLD_STEPS` steps, go to FALL.
  - FALL: duty -= 1 each step. When duty reaches 0, go to IDLE.
  - A restart overrides any state, including mid-RISE, mid-HOLD and mid-FALL.
- PWM:
  - `pwm_cnt` is a free-running `PWM_BITS`-bit counter that wraps.
  - `led[cur_idx]` = (duty > `pwm_cnt`); every other bit is 0.
  - duty 0 gives always-off; maximum duty gives (2^N-1)/2^N on-time.
- Arithmetic: duty is unsigned `PWM_BITS` wide and saturates at both ends; it never wraps.

## Timing
- Reset values:
  - `led` = 0, `sel_err` = 0
  - `sel_q` = 0, `cur_idx` = 0, `have_idx` = 0
  - state = IDLE, duty = 0
  - `pwm_cnt`, step counter, hold counter = 0
- Latency from a `led_select` edge:
  - Change present at edge N is in `sel_q` after N.
  - Restart state is loaded at N+1.
  - `led` reflects the new index at N+2.
- `sel_err` asserts 2 clocks after a bad `led_select` and deasserts 2 clocks after it becomes valid.
- Reset asserted mid-envelope: all outputs drop to 0 asynchronously. The first valid select after release always triggers a restart.
- A restart in the same cycle as a step boundary: the restart wins and no duty update happens.
- Full cycle length = (2·(2^N-1) + `HOLD_STEPS`)·`STEP_DIV` clocks.

## Configuration
- `LED_AFTERGLOW_EN`
  - Defined: a second envelope instance holds the previous index. On restart, it loads the old `cur_idx` and the old duty in state FALL, so the old LED fades out while the new one rises. `led` is the OR of both instances. A restart while the afterglow is still active replaces the afterglow.
  - Undefined: the old LED goes dark immediately, 2 clocks after the change.

## Structure
- Shared package `led_pkg`:
  - `LED_COUNT` = 8
  - typedef `env_state_t` {IDLE, RISE, HOLD, FALL}
- Sub-module `led_envelope`: FSM, duty register, step and hold counters. It takes restart/load-duty/load-state inputs and outputs duty and state. It is instantiated once, or twice with `LED_AFTERGLOW_EN`.

## Test plan
Parameters: `PWM_BITS`=4, `STEP_DIV`=2, `HOLD_STEPS`=3.
- Reset, then `led_select`=8'h01 → `led[0]` stays 0 for 2 clocks; duty reaches 15 after 30 clocks in RISE; HOLD lasts 6 clocks; IDLE is reached after 30 more clocks; `led`=0 thereafter.
- In HOLD, sample `led[0]` over 16 clocks → high in exactly 15 of them.
- Mid-RISE at duty=7, `led_select`=8'h02 → 2 clocks later `led[0]`=0 (macro off), `led[1]` envelope restarts at duty 0.
- `led_select`=8'h03, then 8'h00 → `sel_err`=1 after 2 clocks; `cur_idx` and the envelope are unchanged; returning to 8'h01 clears `sel_err` 2 clocks later.
- Assert `rst_n` mid-FALL → `led`=0 immediately; after release with 8'h01 held, a fresh RISE starts on `led[0]`.
- With `LED_AFTERGLOW_EN`: switch 8'h01→8'h02 in HOLD → `led[0]` falls from 15 to 0 over 30 clocks while `led[1]` rises concurrently.

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg: shared definitions for the LED heartbeat slice.
//   LED_COUNT   - number of board LEDs driven by the one-hot select
//   IDX_BITS    - width of a decoded LED index
//   env_state_t - breathing envelope phases
package led_pkg;

    localparam int unsigned LED_COUNT = 8;
    localparam int unsigned IDX_BITS  = $clog2(LED_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        RISE,
        HOLD,
        FALL
    } env_state_t;

endpackage

// File: rtl/led_envelope.sv
// led_envelope: breathing envelope (rise, hold, fall) for one LED.
// The duty value ramps by one per step, where a step is every STEP_DIV clocks.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   restart     - load load_duty/load_state and clear the step and hold counters
//   load_duty   - duty value taken on restart
//   load_state  - envelope state taken on restart
//   duty        - current duty (0 .. 2^PWM_BITS-1, saturating)
//   state       - current envelope state
module led_envelope
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned STEP_DIV   = 256,
    parameter int unsigned HOLD_STEPS = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                restart,
    input  logic [PWM_BITS-1:0] load_duty,
    input  env_state_t          load_state,
    output logic [PWM_BITS-1:0] duty,
    output env_state_t          state
);

    localparam int unsigned SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_DIV - 1);
    localparam logic [SW-1:0]       STEP_ONE  = SW'(1);
    localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_STEPS - 1);
    localparam logic [HW-1:0]       HOLD_ONE  = HW'(1);
    localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;

    logic [SW-1:0] step_cnt;
    logic [HW-1:0] hold_cnt;
    logic          step;

    assign step = (step_cnt == STEP_LAST);

    // Restart takes priority over a coincident step: no duty update that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            duty     <= '0;
            step_cnt <= '0;
            hold_cnt <= '0;
        end else if (restart) begin
            state    <= load_state;
            duty     <= load_duty;
            step_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            step_cnt <= step ? '0 : step_cnt + STEP_ONE;
            if (step) begin
                case (state)
                    IDLE: duty <= '0;
                    RISE: begin
                        // Transition on the step that makes duty reach full scale.
                        if (duty >= DUTY_MAX - DUTY_ONE) begin
                            duty     <= DUTY_MAX;
                            state    <= HOLD;
                            hold_cnt <= '0;
                        end else begin
                            duty <= duty + DUTY_ONE;
                        end
                    end
                    HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state    <= FALL;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_ONE;
                        end
                    end
                    FALL: begin
                        if (duty <= DUTY_ONE) begin
                            duty  <= '0;
                            state <= IDLE;
                        end else begin
                            duty <= duty - DUTY_ONE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/led_heartbeat_driver.sv
// led_heartbeat_driver: decodes the one-hot LED select and runs a PWM
// breathing envelope on the selected LED each time the selection changes.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   led_select  - one-hot LED select from the selector (registered on entry)
//   led         - registered active-high LED drive
//   sel_err     - registered; high while the sampled select is not one-hot
// Build option: define LED_AFTERGLOW_EN to fade out the previous LED through
// a second envelope while the new one rises; otherwise the old LED goes dark
// as soon as the new index is loaded.
module led_heartbeat_driver
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned STEP_DIV   = 256,
    parameter int unsigned HOLD_STEPS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LED_COUNT-1:0] led_select,
    output logic [LED_COUNT-1:0] led,
    output logic                 sel_err
);

    localparam logic [IDX_BITS:0]   ONES_ONE = (IDX_BITS + 1)'(1);
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);

    logic [LED_COUNT-1:0] sel_q;
    logic [IDX_BITS:0]    ones;
    logic [IDX_BITS-1:0]  idx;
    logic [IDX_BITS-1:0]  cur_idx;
    logic                 valid;
    logic                 have_idx;
    logic                 restart;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic [PWM_BITS-1:0]  duty;
    env_state_t           state;
    logic [LED_COUNT-1:0] led_next;

    always_comb begin
        ones = '0;
        idx  = '0;
        for (int unsigned i = 0; i < LED_COUNT; i++) begin
            if (sel_q[i]) begin
                ones = ones + ONES_ONE;
                idx  = IDX_BITS'(i);
            end
        end
        valid = (ones == ONES_ONE);
    end

    // have_idx forces the first valid select after reset to restart even if
    // it decodes to the reset value of cur_idx.
    assign restart = valid && (!have_idx || (idx != cur_idx));

    led_envelope #(
        .PWM_BITS  (PWM_BITS),
        .STEP_DIV  (STEP_DIV),
        .HOLD_STEPS(HOLD_STEPS)
    ) u_env (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (restart),
        .load_duty ('0),
        .load_state(RISE),
        .duty      (duty),
        .state     (state)
    );

`ifdef LED_AFTERGLOW_EN
    logic [IDX_BITS-1:0] prev_idx;
    logic [PWM_BITS-1:0] ag_duty;
    env_state_t          ag_state;

    // Afterglow takes over the outgoing LED at its current duty and fades it.
    led_envelope #(
        .PWM_BITS  (PWM_BITS),
        .STEP_DIV  (STEP_DIV),
        .HOLD_STEPS(HOLD_STEPS)
    ) u_afterglow (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (restart),
        .load_duty (duty),
        .load_state(FALL),
        .duty      (ag_duty),
        .state     (ag_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_idx <= '0;
        end else if (restart) begin
            prev_idx <= cur_idx;
        end
    end
`endif

    always_comb begin
        led_next = '0;
        if ((state != IDLE) && (duty > pwm_cnt)) begin
            led_next[cur_idx] = 1'b1;
        end
`ifdef LED_AFTERGLOW_EN
        if ((ag_state != IDLE) && (ag_duty > pwm_cnt)) begin
            led_next[prev_idx] = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= '0;
            sel_err  <= 1'b0;
            cur_idx  <= '0;
            have_idx <= 1'b0;
            pwm_cnt  <= '0;
            led      <= '0;
        end else begin
            sel_q   <= led_select;
            sel_err <= !valid;
            pwm_cnt <= pwm_cnt + PWM_ONE;
            led     <= led_next;
            if (restart) begin
                cur_idx  <= idx;
                have_idx <= 1'b1;
            end
        end
    end

endmodule
